texture_buffer_loader: RTL

TEXTURE_BUFFER_LOADER -- requirements
Module: texture_buffer_loader

---
 rtl/texture_buffer_loader_pkg.sv | 18 +
 rtl/texture_buffer_loader.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/texture_buffer_loader_pkg.sv
// Shared texture definitions used by the texel loader and the TMU.
// Holds the loader FSM encoding and the default texel/page geometry so that
// both sides agree on page size and state meaning.
package texture_buffer_loader_pkg;

  // One texture page: 256x256 texels plus the full mipmap chain, in words.
  localparam int unsigned TEX_ADDR_WIDTH  = 17;
  localparam int unsigned TEX_PIXEL_WIDTH = 32;

  // Loader FSM encoding.
  typedef enum logic [1:0] {
    LDR_IDLE   = 2'd0,
    LDR_LOAD   = 2'd1,
    LDR_LOADED = 2'd2,
    LDR_SWAP   = 2'd3
  } ldr_state_e;

endpackage

// File: rtl/texture_buffer_loader.sv
// Texture buffer loader.
// Streams texel words from an AXI-Stream source into the back page of a
// double-buffered texel memory, then swaps front/back pages on request once
// the texture mapping pipeline has drained.
//
// Ports:
//   aclk, resetn           clock, synchronous active-low reset
//   s_axis_tvalid/tready   texel stream handshake
//   s_axis_tdata/tlast     texel word in linear page order / end of texture
//   swapReq                one-cycle pulse asking for a page swap
//   pipelineIdle           texture mapping pipeline holds no fragments
//   readPage               front page select (MSB of texel read addresses)
//   memWe/memAddr/memData  registered write port into the back page
//   loadDone               a complete back page is waiting for a swap
//   overflow               sticky: the load carried more words than a page
module texture_buffer_loader
  import texture_buffer_loader_pkg::*;
#(
  parameter int unsigned PIXEL_WIDTH = TEX_PIXEL_WIDTH,
  parameter int unsigned ADDR_WIDTH  = TEX_ADDR_WIDTH
) (
  input  logic                   aclk,
  input  logic                   resetn,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  input  logic [PIXEL_WIDTH-1:0] s_axis_tdata,
  input  logic                   s_axis_tlast,
  input  logic                   swapReq,
  input  logic                   pipelineIdle,
  output logic                   readPage,
  output logic                   memWe,
  output logic [ADDR_WIDTH:0]    memAddr,
  output logic [PIXEL_WIDTH-1:0] memData,
  output logic                   loadDone,
  output logic                   overflow
);

  // Counter value of the first word past the end of a page; the counter
  // saturates here so it can never wrap back onto valid addresses.
  localparam logic [ADDR_WIDTH:0] WORD_LIMIT = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] COUNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

  ldr_state_e state_q, state_d;

  logic                   read_page_q, read_page_d;
  logic                   mem_we_q,    mem_we_d;
  logic [ADDR_WIDTH:0]    mem_addr_q,  mem_addr_d;
  logic [PIXEL_WIDTH-1:0] mem_data_q,  mem_data_d;
  logic                   load_done_q, load_done_d;
  logic                   overflow_q,  overflow_d;
  logic                   pending_q,   pending_d;
  logic [ADDR_WIDTH:0]    count_q,     count_d;

  logic                   handshake;
  logic [ADDR_WIDTH:0]    beat_idx;
  logic                   beat_ovf;

  assign handshake = s_axis_tvalid & s_axis_tready;

  // State register.
  always_ff @(posedge aclk) begin
    if (!resetn) begin
      state_q <= LDR_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a tlast beat may arrive in IDLE for a one-word load.
  always_comb begin
    state_d = state_q;
    case (state_q)
      LDR_IDLE: begin
        if (handshake) begin
          state_d = s_axis_tlast ? LDR_LOADED : LDR_LOAD;
        end
      end
      LDR_LOAD: begin
        if (handshake && s_axis_tlast) begin
          state_d = LDR_LOADED;
        end
      end
      LDR_LOADED: begin
        if ((swapReq || pending_q) && pipelineIdle) begin
          state_d = LDR_SWAP;
        end
      end
      LDR_SWAP: begin
        state_d = LDR_IDLE;
      end
      default: begin
        state_d = LDR_IDLE;
      end
    endcase
  end

  // FSM outputs. Gating with resetn keeps the stream stalled while reset is held.
  always_comb begin
    s_axis_tready = resetn && ((state_q == LDR_IDLE) || (state_q == LDR_LOAD));
  end

  // Datapath: word counter, write register, status flags and page select.
  // The first beat of a load always lands on word 0 regardless of the stale
  // counter left over from the previous load.
  always_comb begin
    beat_idx    = (state_q == LDR_IDLE) ? '0 : count_q;
    beat_ovf    = (beat_idx == WORD_LIMIT);

    count_d     = count_q;
    mem_we_d    = handshake && !beat_ovf;
    mem_addr_d  = mem_addr_q;
    mem_data_d  = mem_data_q;
    overflow_d  = overflow_q;
    load_done_d = load_done_q;
    pending_d   = pending_q;
    read_page_d = read_page_q;

    if (handshake) begin
      if (state_q == LDR_IDLE) begin
        count_d    = COUNT_ONE;
        overflow_d = 1'b0;
      end else if (count_q != WORD_LIMIT) begin
        count_d = count_q + 1'b1;
      end
      if (beat_ovf) begin
        overflow_d = 1'b1;
      end else begin
        mem_addr_d = {~read_page_q, beat_idx[ADDR_WIDTH-1:0]};
        mem_data_d = s_axis_tdata;
      end
      if (s_axis_tlast) begin
        load_done_d = 1'b1;
      end
    end

    if (swapReq && (state_q != LDR_IDLE)) begin
      pending_d = 1'b1;
    end

    if (state_q == LDR_SWAP) begin
      read_page_d = ~read_page_q;
      pending_d   = 1'b0;
      load_done_d = 1'b0;
    end
  end

  // Datapath registers.
  always_ff @(posedge aclk) begin
    if (!resetn) begin
      read_page_q <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      load_done_q <= 1'b0;
      overflow_q  <= 1'b0;
      pending_q   <= 1'b0;
      count_q     <= '0;
    end else begin
      read_page_q <= read_page_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
      load_done_q <= load_done_d;
      overflow_q  <= overflow_d;
      pending_q   <= pending_d;
      count_q     <= count_d;
    end
  end

  assign readPage = read_page_q;
  assign memWe    = mem_we_q;
  assign memAddr  = mem_addr_q;
  assign memData  = mem_data_q;
  assign loadDone = load_done_q;
  assign overflow = overflow_q;

endmodule
